// File: rtl/adder_result_fifo_if.sv
// Handshake bundle for adder_result_fifo: issue credit, raw adder result, and
// the consumer-side valid/ready result stream.
interface adder_result_fifo_if #(
  parameter int unsigned WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum_in;
  logic             cout_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;

  modport master (
    output in_valid, sum_in, cout_in, out_ready,
    input  in_ready, out_valid, out_sum, out_cout
  );

  modport slave (
    input  in_valid, sum_in, cout_in, out_ready,
    output in_ready, out_valid, out_sum, out_cout
  );
endinterface

// File: rtl/adder_result_fifo.sv
// Capture stage behind the pipelined adder: tracks in-flight issues, stores results
// in a credit-gated FIFO. Optional counters under `ADDER_RESULT_STATS_EN.
module adder_result_fifo #(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned LATENCY = 3,
  parameter int unsigned DEPTH   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  adder_result_fifo_if.slave      bus,
  output logic [$clog2(DEPTH):0]  occupancy
`ifdef ADDER_RESULT_STATS_EN
  ,
  output logic [31:0]             carry_count,
  output logic [31:0]             stall_count
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic             cout;
    logic [WIDTH-1:0] sum;
  } result_t;

  result_t            mem [DEPTH];
  result_t            head;
  logic [LATENCY-1:0] vpipe;
  logic [LATENCY-1:0] vpipe_nxt;
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic [CW-1:0]      count_nxt;
  logic [CW-1:0]      inflight_nxt;
  logic               out_valid_q;
  logic               in_ready_q;
  logic               issue;
  logic               push;
  logic               pop;

  assign issue = bus.in_valid & in_ready_q;
  assign push  = vpipe[LATENCY-1];
  assign pop   = out_valid_q & bus.out_ready;

  // Next-state of the in-flight tracker and the FIFO fill level.
  always_comb begin
    vpipe_nxt    = (vpipe << 1) | LATENCY'(issue);
    count_nxt    = count;
    inflight_nxt = '0;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
    for (int i = 0; i < LATENCY; i++) begin
      inflight_nxt = inflight_nxt + CW'(vpipe_nxt[i]);
    end
  end

  // Credit and valid are registered from next-state so neither sees the consumer combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      vpipe       <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      vpipe       <= vpipe_nxt;
      count       <= count_nxt;
      out_valid_q <= (count_nxt != '0);
      in_ready_q  <= (({1'b0, count_nxt} + {1'b0, inflight_nxt}) < (CW+1)'(DEPTH));
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Result storage; contents are only meaningful between push and pop.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{cout: bus.cout_in, sum: bus.sum_in};
  end

  assign head          = mem[rd_ptr];
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = head.sum;
  assign bus.out_cout  = head.cout;
  assign bus.in_ready  = in_ready_q;
  assign occupancy     = count;

`ifdef ADDER_RESULT_STATS_EN
  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_count <= '0;
      stall_count <= '0;
    end else begin
      if (pop && head.cout && (carry_count != '1))
        carry_count <= carry_count + 32'd1;
      if (bus.in_valid && !in_ready_q && (stall_count != '1))
        stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule
